// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: synchronises the pad, assembles and validates frames, decodes
// make/break/extended codes and feeds four hex-digit decoders (scancode and BCD press count).
module ps2_key_tracker #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [3:0]  dig_en,
  output logic [15:0] dig_data,
  output logic        key_pressed,
  output logic        key_event,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    pclk_q;
  logic [1:0]    pdat_q;
  logic          fall;
  logic [10:0]   shift_q, shift_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          byte_vld_q, byte_vld_d;
  logic [7:0]    byte_q, byte_d;
  logic          ferr_q, ferr_d;
  logic          frame_ok;

  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [7:0]    held_q, held_d;
  logic          held_ext_q, held_ext_d;
  logic          pressed_q, pressed_d;
  logic          event_q, event_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic          key_match;

  assign fall     = pclk_q[2] & ~pclk_q[1];
  assign shift_d  = fall ? {pdat_q[1], shift_q[10:1]} : shift_q;
  // Odd parity: data bits plus parity bit must XOR to 1.
  assign frame_ok = ~shift_d[0] & shift_d[10] & (^shift_d[9:1]);

  always_comb begin
    bitcnt_d   = bitcnt_q;
    idle_d     = idle_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    ferr_d     = 1'b0;
    if (fall) begin
      idle_d = '0;
      if (bitcnt_q == 4'd10) begin
        bitcnt_d = 4'd0;
        if (frame_ok) begin
          byte_vld_d = 1'b1;
          byte_d     = shift_d[8:1];
        end else begin
          ferr_d = 1'b1;
        end
      end else begin
        bitcnt_d = bitcnt_q + 4'd1;
      end
    end else if (bitcnt_q != 4'd0) begin
      if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bitcnt_d = 4'd0;
        idle_d   = '0;
        ferr_d   = 1'b1;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end

  assign key_match = pressed_q && (byte_q == held_q) && (ext_q == held_ext_q);

  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    held_d     = held_q;
    held_ext_d = held_ext_q;
    pressed_d  = pressed_q;
    event_d    = 1'b0;
    ones_d     = ones_q;
    tens_d     = tens_q;
    if (byte_vld_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!brk_q) begin
          // A repeat of the held key is typematic and ignored.
          if (!key_match) begin
            held_d     = byte_q;
            held_ext_d = ext_q;
            pressed_d  = 1'b1;
            event_d    = 1'b1;
            if (ones_q == 4'd9) begin
              ones_d = 4'd0;
              tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end
        end else if (key_match) begin
          pressed_d = 1'b0;
          event_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pclk_q     <= '0;
      pdat_q     <= '0;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      idle_q     <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      ferr_q     <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      held_q     <= '0;
      held_ext_q <= 1'b0;
      pressed_q  <= 1'b0;
      event_q    <= 1'b0;
      ones_q     <= '0;
      tens_q     <= '0;
    end else begin
      pclk_q     <= {pclk_q[1:0], ps2_clk};
      pdat_q     <= {pdat_q[0], ps2_data};
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      idle_q     <= idle_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      ferr_q     <= ferr_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      held_q     <= held_d;
      held_ext_q <= held_ext_d;
      pressed_q  <= pressed_d;
      event_q    <= event_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
    end
  end

  assign dig_en      = {2'b11, pressed_q, pressed_q};
  assign dig_data    = {tens_q, ones_q, held_q};
  assign key_pressed = pressed_q;
  assign key_event   = event_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomised bench for ps2_key_tracker against a frame-level behavioural model of the keyboard.
module tb_ps2_key_tracker;

  localparam int unsigned TO = 200;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [3:0]  dig_en;
  logic [15:0] dig_data;
  logic        key_pressed, key_event, frame_err;

  ps2_key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .dig_en(dig_en), .dig_data(dig_data), .key_pressed(key_pressed),
    .key_event(key_event), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int nchecks = 0, nerrs = 0;
  int ev_cnt = 0, err_cnt = 0;
  bit chk_en = 0;

  // Behavioural model
  bit m_pressed, m_hext, m_ext, m_brk;
  logic [7:0] m_held;
  int m_count, m_ev = 0, m_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_data();
    logic [3:0] t, o;
    t = 4'(m_count / 10);
    o = 4'(m_count % 10);
    return {t, o, m_held};
  endfunction

  task automatic model_reset();
    m_pressed = 0; m_hext = 0; m_ext = 0; m_brk = 0; m_held = 8'h00; m_count = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit same;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      same = m_pressed && b == m_held && m_ext == m_hext;
      if (!m_brk && !same) begin
        m_held = b; m_hext = m_ext; m_pressed = 1;
        m_count = (m_count + 1) % 100;
        m_ev++;
      end else if (m_brk && same) begin
        m_pressed = 0;
        m_ev++;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  always @(negedge clk) begin
    if (key_event) ev_cnt++;
    if (frame_err) err_cnt++;
    check("pulse_overlap", {31'b0, key_event & frame_err}, 32'd0);
    if (chk_en) begin
      check("dig_en", {28'b0, dig_en}, {28'b0, 2'b11, m_pressed, m_pressed});
      check("dig_data", {16'b0, dig_data}, {16'b0, m_data()});
      check("key_pressed", {31'b0, key_pressed}, {31'b0, m_pressed});
      check("event_count", ev_cnt, m_ev);
      check("err_count", err_cnt, m_err);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    int half;
    half = $urandom_range(6, 10);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      tick(half);
      ps2_clk = 1'b0;
      tick(half);
      ps2_clk = 1'b1;
    end
    tick(half);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    chk_en = 0;
    send_bits(mk_frame(b, 0, 0), 11);
    tick(4);
    model_byte(b);
    chk_en = 1;
  endtask

  task automatic send_bad(input bit bad_par);
    chk_en = 0;
    send_bits(mk_frame(8'h1C, bad_par, !bad_par), 11);
    tick(4);
    m_err++;
    chk_en = 1;
  endtask

  task automatic send_partial(input int n);
    chk_en = 0;
    send_bits(mk_frame(8'h55, 0, 0), n);
    tick(TO + 20);
    m_err++;
    chk_en = 1;
  endtask

  task automatic do_reset();
    chk_en = 0;
    clrn = 1'b0;
    tick(3);
    clrn = 1'b1;
    model_reset();
    tick(3);
    chk_en = 1;
  endtask

  logic [7:0] codes [6] = '{8'h1C, 8'h32, 8'h75, 8'hE0, 8'hF0, 8'h23};

  initial begin
    int ev0, r;
    model_reset();
    tick(5);
    clrn = 1'b1;
    tick(3);
    chk_en = 1;
    check("rst_dig_en", {28'b0, dig_en}, 32'hC);
    check("rst_dig_data", {16'b0, dig_data}, 32'h0);

    // Reset mid-frame after 5 bits
    chk_en = 0;
    send_bits(mk_frame(8'h1C, 0, 0), 5);
    do_reset();
    tick(20);
    check("midrst_dig_en", {28'b0, dig_en}, 32'hC);
    check("midrst_errs", err_cnt, 0);

    // Make / break
    send_byte(8'h1C);
    check("make_dig_data", {16'b0, dig_data}, 32'h011C);
    check("make_dig_en", {28'b0, dig_en}, 32'hF);
    check("make_events", ev_cnt, 1);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("brk_dig_data", {16'b0, dig_data}, 32'h011C);
    check("brk_dig_en", {28'b0, dig_en}, 32'hC);
    check("brk_events", ev_cnt, 2);

    // Typematic
    do_reset();
    ev0 = ev_cnt;
    repeat (5) send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("typ_events", ev_cnt - ev0, 2);
    check("typ_count", {24'b0, dig_data[15:8]}, 32'h01);
    send_byte(8'h32);
    check("typ_next", {16'b0, dig_data}, 32'h0232);

    // Extended
    do_reset();
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hF0); send_byte(8'h75);
    check("ext_still_held", {31'b0, key_pressed}, 32'd1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("ext_released", {31'b0, key_pressed}, 32'd0);
    check("ext_count", {16'b0, dig_data}, 32'h0175);

    // Frame errors
    ev0 = err_cnt;
    send_bad(1);
    send_bad(0);
    send_partial(6);
    check("err_pulses", err_cnt - ev0, 3);
    check("err_state", {16'b0, dig_data}, 32'h0175);
    send_byte(8'h23);
    check("after_err", {16'b0, dig_data}, 32'h0223);

    // Wrap
    do_reset();
    for (int i = 0; i < 100; i++) begin
      send_byte((i % 2 == 0) ? 8'h1C : 8'h32);
      if (i == 98) check("wrap_99", {24'b0, dig_data[15:8]}, 32'h99);
    end
    check("wrap_00", {24'b0, dig_data[15:8]}, 32'h00);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) send_bad(1);
      else if (r < 10) send_bad(0);
      else if (r < 13) send_partial($urandom_range(1, 10));
      else send_byte(codes[$urandom_range(0, 5)]);
    end
    tick(10);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
